width_downsizer: RTL and testbench
==================================

# width_downsizer

Parametrised successor of the 64→8 serializer: buffers wide input words in an internal FIFO and emits them as narrower chunks on request, one chunk per accepted `req_data`. It sits between a wide producer that uses a write strobe and a narrow consumer that polls `ready` and issues `req_data`. The block adds configurable widths, a word FIFO, selectable chunk order, occupancy/full status and optional overflow accounting.

## Interface
- `IN_W`, default 64: input word width; must be a multiple of `OUT_W`.
- `OUT_W`, default 8: output chunk width; `N = IN_W/OUT_W` must be ≥ 2.
- `DEPTH`, default 4: FIFO depth in words; must be a power of 2 and ≥ 2.
- `MSB_FIRST`, default 0: 0 emits the least-significant chunk first; 1 emits the most-significant chunk first.

- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `strobe_in`  in  1  write strobe; `input_data` is sampled when it is 1.
- `input_data`  in  IN_W  input word.
- `full`  out  1  FIFO holds `DEPTH` words.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the word in the shifter.
- `req_data`  in  1  chunk request; acted on only while `ready`=1.
- `ready`  out  1  the shifter holds an unsent chunk.
- `strobe_out`  out  1  one-cycle pulse marking `data_out` valid.
- `data_out`  out  OUT_W  output chunk; holds its last value between strobes.
- `data_end`  out  1  asserted together with `strobe_out` on the last chunk of a word.
- `overflow`  out  1  sticky dropped-write flag; present only with the macro (see Configuration).
- `ovf_cnt`  out  8  count of dropped writes, saturating at 255; present only with the macro.

## Operation
- FIFO write: a write is accepted iff `strobe_in`=1 and `level` < `DEPTH` at the sampling edge.
  - This holds regardless of a same-cycle pop.
  - A write while full is dropped.
- FSM, two states:
  - `ST_EMPTY`: the shifter is empty. If `level` > 0, pop the head word into the shifter, set the chunk index to 0 and go to `ST_ACTIVE`.
  - `ST_ACTIVE`: `ready` is 1. On `req_data`=1, present chunk `idx` and increment `idx`.
- Chunk selection:
  - `MSB_FIRST`=0: chunk k = `word[k*OUT_W +: OUT_W]`.
  - `MSB_FIRST`=1: chunk k = `word[(N-1-k)*OUT_W +: OUT_W]`.
- Last chunk (`idx` = N-1 accepted):
  - `data_end`=1 alongside that strobe.
  - If `level` > 0 in the same cycle, pop the next word, reset `idx` to 0 and stay in `ST_ACTIVE` (no gap).
  - Otherwise go to `ST_EMPTY`.
- `req_data` while `ready`=0 is ignored, with no side effects.
- Push and pop in the same cycle leave `level` unchanged. The FIFO pointers wrap modulo `DEPTH`.
- Reset, including mid-word: clears the FIFO, `idx`, FSM and all outputs. A partially sent word is discarded.

## Timing
- Reset values: `ready`, `strobe_out`, `data_end`, `full` = 0; `data_out`, `level` = 0; `overflow`, `ovf_cnt` = 0. FSM resets to `ST_EMPTY`.
- Fill latency: `strobe_in` sampled at edge t into an empty block gives `level`=1 after t. The pop happens at t+1, so `ready`=1 after t+1 and `level` returns to 0.
- Request latency: `req_data` sampled at edge t gives `strobe_out`, `data_out` and `data_end` valid after t, for one cycle.
- Throughput: with `req_data` held at 1, one chunk per cycle, continuous across words while the FIFO is non-empty.
- `ready` falls after the edge that accepts the final chunk of the last buffered word, i.e. in the same cycle as that final strobe.
- All outputs are registered.

## Configuration
- `WIDTH_DOWNSIZER_OVF_EN` defined:
  - `overflow` and `ovf_cnt` ports exist.
  - Each dropped write sets `overflow` and increments `ovf_cnt` one cycle later.
  - Both are cleared only by `reset`.
- Not defined: the ports and logic are absent, and dropped writes are silently discarded.

## Structure
- Package `width_downsizer_pkg`:
  - `state_t` enum {`ST_EMPTY`, `ST_ACTIVE`}.
  - Constant `OVF_CNT_W` = 8.
- Sub-module `width_downsizer_fifo`: synchronous FIFO parametrised by width and depth, providing push/pop, `full`/empty and `level`.
- Top level: FSM, shifter/mux, chunk counter, and the optional overflow logic.

## Test plan
- Reset held 10 cycles with random inputs → every output 0; `level`=0 throughout.
- Write 0x0807060504030201 with `req_data` held at 1 → 8 consecutive strobes, `data_out` = 01,02…08; `data_end` only with 08; `ready` low from the 08 cycle.
- Same word with `MSB_FIRST`=1 → `data_out` = 08,07…01.
- Five back-to-back writes with `req_data`=0 → `level`=4, `full`=1. A 6th write is dropped, giving `overflow`=1 and `ovf_cnt`=1 with the macro. Draining then yields 40 contiguous strobes and 5 `data_end` pulses, in write order.
- Reset asserted after 3 chunks of a word → all outputs 0 next cycle. A new word then starts from chunk 0.
- `req_data` pulses while `ready`=0 → no `strobe_out`; state unchanged.

Source files
------------

// File: rtl/width_downsizer_pkg.sv
// Shared types and constants for the width downsizer (FSM states, overflow counter width).
package width_downsizer_pkg;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam int OVF_CNT_W = 8;

endpackage

// File: rtl/width_downsizer_fifo.sv
// Synchronous word FIFO with registered level/full/empty; a push is refused only when full,
// independent of a same-cycle pop.
module width_downsizer_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  logic [LW-1:0] level_d;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    level_d = level;
    case ({do_push, do_pop})
      2'b10:   level_d = level + LW'(1);
      2'b01:   level_d = level - LW'(1);
      default: level_d = level;
    endcase
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_d;
      full  <= (level_d == LW'(DEPTH));
      empty <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/width_downsizer.sv
// Wide-to-narrow serializer: FIFO of IN_W words, emitted as OUT_W chunks on req_data.
// Optional overflow accounting is built when WIDTH_DOWNSIZER_OVF_EN is defined.
module width_downsizer
  import width_downsizer_pkg::*;
#(
  parameter int IN_W      = 64,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   strobe_in,
  input  logic [IN_W-1:0]        input_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   req_data,
  output logic                   ready,
  output logic                   strobe_out,
  output logic [OUT_W-1:0]       data_out,
  output logic                   data_end
`ifdef WIDTH_DOWNSIZER_OVF_EN
  ,
  output logic                   overflow,
  output logic [OVF_CNT_W-1:0]   ovf_cnt
`endif
);

  localparam int N     = IN_W / OUT_W;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_t                  state_q, state_d;
  logic [N-1:0][OUT_W-1:0] word_q;
  logic [IDX_W-1:0]        idx_q;
  logic [OUT_W-1:0]        chunk;
  logic [IN_W-1:0]         fifo_rdata;
  logic                    fifo_empty;
  logic                    pop, take, last;

  width_downsizer_fifo #(.W(IN_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (strobe_in),
    .push_data (input_data),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (full),
    .empty     (fifo_empty),
    .level     (level)
  );

  if (MSB_FIRST != 0) begin : g_msb
    assign chunk = word_q[IDX_LAST - idx_q];
  end else begin : g_lsb
    assign chunk = word_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // On the final chunk, a waiting word is loaded in the same cycle so a held req_data sees no gap.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    take    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (req_data) begin
          take = 1'b1;
          last = (idx_q == IDX_LAST);
          if (last) begin
            if (!fifo_empty) pop = 1'b1;
            else             state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign ready = (state_q == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q     <= '0;
      idx_q      <= '0;
      strobe_out <= 1'b0;
      data_end   <= 1'b0;
      data_out   <= '0;
    end else begin
      strobe_out <= take;
      data_end   <= take && last;
      if (take) data_out <= chunk;
      if (pop) begin
        word_q <= fifo_rdata;
        idx_q  <= '0;
      end else if (take) begin
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

`ifdef WIDTH_DOWNSIZER_OVF_EN
  // full is the registered FIFO flag, i.e. exactly the "write refused" condition this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      ovf_cnt  <= '0;
    end else if (strobe_in && full) begin
      overflow <= 1'b1;
      if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_width_downsizer.sv
// Bench for width_downsizer: LSB-first and MSB-first instances on shared stimulus, checked
// against a queue-based reference model. Overflow checks apply when WIDTH_DOWNSIZER_OVF_EN is defined.
module tb_width_downsizer;
  localparam int IN_W = 64, OUT_W = 8, DEPTH = 4, N = IN_W / OUT_W;
  localparam int LW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset, strobe_in, req_data;
  logic [IN_W-1:0] input_data;
  logic full0, full1, ready0, ready1, so0, so1, de0, de1;
  logic [LW-1:0] lvl0, lvl1;
  logic [OUT_W-1:0] d0, d1;
`ifdef WIDTH_DOWNSIZER_OVF_EN
  logic ovf0, ovf1;
  logic [7:0] oc0, oc1;
  bit m_ovf;
  int m_cnt;
`endif

  int errors = 0, checks = 0;

  // reference model state
  logic [IN_W-1:0] m_q[$];
  logic [IN_W-1:0] m_word;
  int m_idx;
  bit m_act, m_so, m_de;
  logic [OUT_W-1:0] m_d0, m_d1;

  always #5 clk = ~clk;

  width_downsizer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .strobe_in(strobe_in), .input_data(input_data),
    .full(full0), .level(lvl0), .req_data(req_data), .ready(ready0),
    .strobe_out(so0), .data_out(d0), .data_end(de0)
`ifdef WIDTH_DOWNSIZER_OVF_EN
    , .overflow(ovf0), .ovf_cnt(oc0)
`endif
  );

  width_downsizer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .strobe_in(strobe_in), .input_data(input_data),
    .full(full1), .level(lvl1), .req_data(req_data), .ready(ready1),
    .strobe_out(so1), .data_out(d1), .data_end(de1)
`ifdef WIDTH_DOWNSIZER_OVF_EN
    , .overflow(ovf1), .ovf_cnt(oc1)
`endif
  );

  function automatic logic [OUT_W-1:0] chunk_of(input logic [IN_W-1:0] w, input int k);
    logic [IN_W-1:0] s;
    s = w >> (k * OUT_W);
    return s[OUT_W-1:0];
  endfunction

  // One clock edge: advance the model from the inputs present at the edge, then settle.
  task automatic tick();
    int lvl;
    bit pop_w, push_ok;
    @(posedge clk);
    if (reset) begin
      m_q.delete(); m_act = 0; m_idx = 0; m_so = 0; m_de = 0; m_d0 = '0; m_d1 = '0;
`ifdef WIDTH_DOWNSIZER_OVF_EN
      m_ovf = 0; m_cnt = 0;
`endif
    end else begin
      lvl = m_q.size(); pop_w = 0; m_so = 0; m_de = 0;
      if (!m_act) pop_w = (lvl > 0);
      else if (req_data) begin
        m_so = 1; m_de = (m_idx == N - 1);
        m_d0 = chunk_of(m_word, m_idx);
        m_d1 = chunk_of(m_word, N - 1 - m_idx);
        m_idx++;
        if (m_idx == N) begin
          if (lvl > 0) pop_w = 1;
          else m_act = 0;
        end
      end
      push_ok = strobe_in && (lvl < DEPTH);
`ifdef WIDTH_DOWNSIZER_OVF_EN
      if (strobe_in && !push_ok) begin m_ovf = 1; if (m_cnt < 255) m_cnt++; end
`endif
      if (pop_w) begin m_word = m_q.pop_front(); m_idx = 0; m_act = 1; end
      if (push_ok) m_q.push_back(input_data);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    for (int c = 0; c < 10; c++) begin
      strobe_in = 1'($urandom); req_data = 1'($urandom);
      input_data = {$urandom, $urandom};
      tick();
      checks++;
      if ({so0, de0, ready0, full0, lvl0, d0, so1, de1, ready1, full1, lvl1, d1} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: got so=%b de=%b rdy=%b full=%b lvl=%0d d=%h / msb d=%h, want all 0",
                 c, so0, de0, ready0, full0, lvl0, d0, d1);
      end
`ifdef WIDTH_DOWNSIZER_OVF_EN
      checks++;
      if ({ovf0, oc0, ovf1, oc1} !== '0) begin
        errors++;
        $display("FAIL reset_ovf: got ovf=%b cnt=%0d, want 0", ovf0, oc0);
      end
`endif
    end
    reset = 0; strobe_in = 0; req_data = 0; input_data = '0;
    tick();
  endtask

  task automatic test_single_word();
    logic [IN_W-1:0] w;
    logic [OUT_W-1:0] g0[$], g1[$];
    int ends = 0, first = -1, lastc = -1;
    w = 64'h0807060504030201;
    strobe_in = 1; input_data = w; req_data = 1;
    tick();
    strobe_in = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (so0) begin
        g0.push_back(d0);
        if (first < 0) first = c;
        lastc = c;
      end
      if (so1) g1.push_back(d1);
      if (de0) begin
        ends++;
        checks++;
        if (d0 !== 8'h08 || ready0 !== 1'b0) begin
          errors++;
          $display("FAIL single_end: got d=%h ready=%b with data_end, want d=08 ready=0", d0, ready0);
        end
      end
    end
    checks++;
    if (g0.size() != 8 || g1.size() != 8 || ends != 1 || (lastc - first) != 7) begin
      errors++;
      $display("FAIL single_counts: got lsb=%0d msb=%0d strobes, %0d ends, span %0d; want 8,8,1,7",
               g0.size(), g1.size(), ends, lastc - first);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (g0[i] !== 8'(i + 1) || g1[i] !== 8'(8 - i)) begin
          errors++;
          $display("FAIL single_chunk %0d: got lsb=%h msb=%h want %h %h", i, g0[i], g1[i], 8'(i + 1), 8'(8 - i));
        end
      end
    end
    req_data = 0;
  endtask

  task automatic test_fill_and_drain();
    logic [IN_W-1:0] w[6];
    int ns = 0, ne = 0, first = -1, lastc = -1;
    req_data = 0;
    for (int i = 0; i < 6; i++) begin
      w[i] = {$urandom, $urandom};
      strobe_in = 1; input_data = w[i];
      tick();
    end
    strobe_in = 0;
    checks++;
    if (lvl0 !== LW'(4) || full0 !== 1'b1 || ready0 !== 1'b1) begin
      errors++;
      $display("FAIL fill_status: got level=%0d full=%b ready=%b, want 4 1 1", lvl0, full0, ready0);
    end
`ifdef WIDTH_DOWNSIZER_OVF_EN
    checks++;
    if (ovf0 !== 1'b1 || oc0 !== 8'd1) begin
      errors++;
      $display("FAIL fill_overflow: got ovf=%b cnt=%0d, want 1 1", ovf0, oc0);
    end
`endif
    req_data = 1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (so0) begin
        if (first < 0) first = c;
        lastc = c;
        if (ns < 40) begin
          checks++;
          if (d0 !== chunk_of(w[ns / N], ns % N) || d1 !== chunk_of(w[ns / N], N - 1 - ns % N)) begin
            errors++;
            $display("FAIL drain_chunk %0d: got %h/%h want %h/%h", ns, d0, d1,
                     chunk_of(w[ns / N], ns % N), chunk_of(w[ns / N], N - 1 - ns % N));
          end
        end
        ns++;
      end
      if (de0) ne++;
    end
    checks++;
    if (ns != 40 || ne != 5 || (lastc - first) != 39 || ready0 !== 1'b0 || lvl0 !== '0) begin
      errors++;
      $display("FAIL drain_counts: got %0d strobes %0d ends span %0d ready=%b level=%0d; want 40 5 39 0 0",
               ns, ne, lastc - first, ready0, lvl0);
    end
    req_data = 0;
  endtask

  task automatic test_reset_mid_word();
    logic [IN_W-1:0] w;
    int seen = 0;
    req_data = 0;
    for (int i = 0; i < 2; i++) begin
      strobe_in = 1; input_data = {$urandom, $urandom}; tick();
    end
    strobe_in = 0; req_data = 1;
    for (int c = 0; c < 20 && seen < 3; c++) begin
      tick();
      if (so0) seen++;
    end
    checks++;
    if (seen != 3) begin
      errors++;
      $display("FAIL midreset_setup: got %0d strobes, want 3", seen);
    end
    reset = 1;
    tick();
    checks++;
    if ({so0, de0, ready0, full0, lvl0, d0, so1, ready1, lvl1, d1} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got so=%b de=%b rdy=%b full=%b lvl=%0d d=%h, want all 0",
               so0, de0, ready0, full0, lvl0, d0);
    end
    reset = 0; req_data = 1;
    w = {$urandom, $urandom};
    strobe_in = 1; input_data = w; tick();
    strobe_in = 0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      if (so0) begin
        seen = 1;
        checks++;
        if (d0 !== w[7:0] || d1 !== w[63:56] || de0 !== 1'b0) begin
          errors++;
          $display("FAIL midreset_restart: got %h/%h end=%b want %h/%h end=0", d0, d1, de0, w[7:0], w[63:56]);
        end
      end
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL midreset_timeout: got no strobe within 10 cycles, want one");
    end
  endtask

  task automatic test_req_when_idle();
    logic [OUT_W-1:0] held;
    req_data = 1;
    for (int c = 0; c < 30 && (ready0 || lvl0 != 0); c++) tick();
    tick();
    held = d0;
    for (int c = 0; c < 8; c++) begin
      req_data = 1'($urandom); strobe_in = 0;
      tick();
      checks++;
      if (so0 !== 1'b0 || so1 !== 1'b0 || ready0 !== 1'b0 || lvl0 !== '0 || d0 !== held || de0 !== 1'b0) begin
        errors++;
        $display("FAIL idle_req cyc %0d: got so=%b rdy=%b lvl=%0d d=%h want 0 0 0 %h", c, so0, ready0, lvl0, d0, held);
      end
    end
    req_data = 0;
  endtask

  task automatic test_random();
    logic [4+LW+OUT_W-1:0] exp0, got0, exp1, got1;
    int pct[4] = '{5, 10, 30, 60};
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 499) == 0);
      strobe_in  = ($urandom_range(0, 99) < pct[(i / 256) % 4]);
      req_data   = ($urandom_range(0, 99) < pct[(i / 384) % 4] + 35);
      input_data = {$urandom, $urandom};
      tick();
      exp0 = {m_so, m_de, m_act, (m_q.size() == DEPTH), LW'(m_q.size()), m_d0};
      exp1 = {m_so, m_de, m_act, (m_q.size() == DEPTH), LW'(m_q.size()), m_d1};
      got0 = {so0, de0, ready0, full0, lvl0, d0};
      got1 = {so1, de1, ready1, full1, lvl1, d1};
      checks++;
      if (got0 !== exp0 || got1 !== exp1) begin
        errors++;
        $display("FAIL random cyc %0d: got lsb=%h msb=%h want %h %h (so,end,rdy,full,lvl,data)", i, got0, got1, exp0, exp1);
      end
`ifdef WIDTH_DOWNSIZER_OVF_EN
      checks++;
      if (ovf0 !== m_ovf || oc0 !== 8'(m_cnt) || ovf1 !== m_ovf || oc1 !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL random_ovf cyc %0d: got ovf=%b cnt=%0d want %b %0d", i, ovf0, oc0, m_ovf, m_cnt);
      end
`endif
    end
    reset = 0; strobe_in = 0; req_data = 0;
  endtask

  initial begin
    reset = 1; strobe_in = 0; req_data = 0; input_data = '0;
    test_reset();
    test_single_word();
    test_fill_and_drain();
    test_reset_mid_word();
    test_req_when_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
